i2c_target_regs: RTL and testbench
==================================

// Module: i2c_target_regs
// PURPOSE
//  I2C target (responder) for 7-bit addressing, standard/fast mode. It exposes an 8-bit register
//  space to an off-chip I2C controller through an 8-bit auto-incrementing pointer. It sits on the
//  same SCL/SDA pins a pass-through I2C bridge would forward, and lets the FPGA answer as a device
//  on the bus. Register storage lives outside the block: writes leave on a strobe interface and
//  reads are fetched with one CLK of latency.
// PARAMETERS
//  TARGET_ADDR  7'h42  7-bit I2C address this block answers to
//  PTR_RESET    8'h00  pointer value after reset
// PORTS
//  CLK          in     1  system clock; must be >= 16x SCL frequency
//  RST          in     1  reset, asynchronous, active-high
//  SCL          in     1  I2C clock from controller (no clock stretching)
//  SDA          inout  1  I2C data; block drives 1'b0 or 1'bz only
//  REG_WR_EN    out    1  1-CLK write strobe
//  REG_WR_ADDR  out    8  write address (pointer value at strobe)
//  REG_WR_DATA  out    8  write data
//  REG_RD_STB   out    1  1-CLK read-request strobe; address on REG_RD_ADDR
//  REG_RD_ADDR  out    8  read address (pointer value at strobe)
//  REG_RD_DATA  in     8  read data; must be valid the CLK after REG_RD_STB
//  BUSY         out    1  high from address match until STOP, repeated START, or NACK
// BEHAVIOUR
//  - Input sync: SCL and SDA each pass through a 2-FF synchroniser. Rise/fall edges of SCL are
//    1-CLK pulses on the synced samples.
//  - START is SDA falling while SCL is high; STOP is SDA rising while SCL is high. Both are
//    detected on synced samples.
//  - Bit timing: bits are sampled on SCL rise, MSB first. SDA drive changes only in the CLK after a
//    detected SCL fall, never while SCL is high.
//  - FSM states: IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
//  - IDLE -> DEV_ADDR on START.
//  - DEV_ADDR: shift 8 bits, then compare [7:1] with TARGET_ADDR.
//    - Mismatch: go to IDLE, SDA stays released; ignore the bus until the next START.
//    - Match: go to DEV_ACK and drive SDA=0 for the 9th clock.
//  - DEV_ACK, R/W=0: next state is PTR.
//  - DEV_ACK, R/W=1: assert REG_RD_STB in the CLK of the match and latch REG_RD_DATA into the
//    shift register the next CLK, then go to RD_DATA.
//  - PTR: 8 bits load the pointer -> PTR_ACK (ACK driven) -> WR_DATA.
//  - WR_DATA: 8 bits -> WR_ACK (ACK driven). REG_WR_EN pulses once in the CLK after the 8th SCL
//    rise, with REG_WR_ADDR = pointer. The pointer then increments -> WR_DATA.
//  - RD_DATA: drive shift-register bits (a 1 releases SDA). After the 8th bit, release SDA ->
//    RD_ACK, and sample the controller's bit on SCL rise.
//    - ACK (0): increment pointer, pulse REG_RD_STB, reload shift register -> RD_DATA.
//    - NACK (1): go to IDLE, BUSY drops, SDA released.
//  - Pointer: 8-bit, wraps 8'hFF -> 8'h00. It persists across transactions, so a write of pointer
//    only, then repeated START plus read, reads from that pointer.
//  - Repeated START in any state: go to DEV_ADDR, bit counter cleared, SDA released, pointer kept.
//  - STOP in any state: go to IDLE, SDA released, BUSY=0. A partial data byte is discarded with no
//    REG_WR_EN.
//  - Reset values: FSM=IDLE, SDA=z, REG_WR_EN=0, REG_RD_STB=0, REG_WR_ADDR=0, REG_WR_DATA=0,
//    REG_RD_ADDR=PTR_RESET, BUSY=0, pointer=PTR_RESET.
//  - Reset mid-transfer releases SDA immediately (asynchronous).
//  - General call (address 0) is not acknowledged.
// CONFIGURATION
//  I2C_GLITCH_FILTER_EN
//  - Defined: a 3-sample stable filter follows each synchroniser. A level change is accepted only
//    after 3 equal consecutive samples, which removes pulses shorter than 3 CLK and adds 2 CLK of
//    latency to all edge, START and STOP detection. CLK must then be >= 24x SCL.
//  - Undefined: no filter; edges are taken directly from the 2-FF outputs.
// TESTING
//  - Write of 0x42/W, ptr 0x10, data 0xA5, 0x5A, STOP -> three ACKs; REG_WR_EN at addr 0x10 data
//    0xA5, then addr 0x11 data 0x5A; BUSY falls on STOP.
//  - Write of 0x42/W, ptr 0x20, repeated START, 0x42/R, bench returns 0x11 then 0x22; controller
//    ACKs then NACKs -> SDA carries 0x11, 0x22; REG_RD_ADDR 0x20, 0x21; FSM ends in IDLE.
//  - Address 0x43/W, data 0xFF -> SDA never driven low; no REG_WR_EN; BUSY stays 0.
//  - Pointer 0xFF, write 0x01, 0x02 -> REG_WR_EN at addr 0xFF then addr 0x00 (wrap).
//  - STOP after 4 bits of a data byte -> no REG_WR_EN; SDA released. RST asserted during a read
//    byte -> SDA=z in the same cycle; all outputs at reset values.
//  - With I2C_GLITCH_FILTER_EN: a 2-CLK low glitch on SCL during a write has no effect and the
//    byte is still received correctly. Without the macro, the same glitch corrupts the bit count.

Source files
------------

// File: rtl/i2c_target_regs_if.sv
// Register-side strobe bundle of i2c_target_regs.
// master: the I2C target (issues strobes); slave: the register storage (returns read data).
interface i2c_target_regs_if;
    logic       REG_WR_EN;
    logic [7:0] REG_WR_ADDR;
    logic [7:0] REG_WR_DATA;
    logic       REG_RD_STB;
    logic [7:0] REG_RD_ADDR;
    logic [7:0] REG_RD_DATA;

    modport master (
        output REG_WR_EN, REG_WR_ADDR, REG_WR_DATA,
        output REG_RD_STB, REG_RD_ADDR,
        input  REG_RD_DATA
    );

    modport slave (
        input  REG_WR_EN, REG_WR_ADDR, REG_WR_DATA,
        input  REG_RD_STB, REG_RD_ADDR,
        output REG_RD_DATA
    );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C 7-bit target exposing an 8-bit auto-incrementing register pointer.
// Ports: CLK, RST (async, active-high), SCL in, SDA open-drain inout, BUSY out,
// regs (master): write strobe/addr/data, read strobe/addr, read data back 1 CLK later.
// Optional I2C_GLITCH_FILTER_EN: 3-sample stable filter after each synchroniser.
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter logic [7:0] PTR_RESET   = 8'h00
) (
    input  logic CLK,
    input  logic RST,
    input  logic SCL,
    inout  wire  SDA,
    output logic BUSY,
    i2c_target_regs_if.master regs
);
    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK,
        WR_DATA, WR_ACK, RD_DATA, RD_ACK
    } state_t;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_lvl_q, sda_lvl_q;
    logic       scl_lvl_d, sda_lvl_d;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;
    logic       ld_q, ld_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       rd_stb_q, rd_stb_d;
    logic [7:0] rd_addr_q, rd_addr_d;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in;
    logic       addr_hit;

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, sda_hist_q;

    // A level is accepted only once three consecutive samples agree.
    always_comb begin
        scl_lvl_d = scl_lvl_q;
        sda_lvl_d = sda_lvl_q;
        if (scl_sync_q[1] == scl_hist_q[0] && scl_hist_q[0] == scl_hist_q[1])
            scl_lvl_d = scl_sync_q[1];
        if (sda_sync_q[1] == sda_hist_q[0] && sda_hist_q[0] == sda_hist_q[1])
            sda_lvl_d = sda_sync_q[1];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
        end
    end
`else
    always_comb begin
        scl_lvl_d = scl_sync_q[1];
        sda_lvl_d = sda_sync_q[1];
    end
`endif

    assign scl_rise  =  scl_lvl_d & ~scl_lvl_q;
    assign scl_fall  = ~scl_lvl_d &  scl_lvl_q;
    assign start_det = ~sda_lvl_d &  sda_lvl_q & scl_lvl_d;
    assign stop_det  =  sda_lvl_d & ~sda_lvl_q & scl_lvl_d;
    assign byte_in   = {shift_q[6:0], sda_lvl_d};
    // General call (address 0) is never acknowledged.
    assign addr_hit  = (byte_in[7:1] == TARGET_ADDR) && (byte_in[7:1] != 7'd0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        ld_d      = rd_stb_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_stb_d  = 1'b0;
        rd_addr_d = rd_addr_q;

        // Read data arrives the CLK after the strobe.
        if (ld_q)
            shift_d = regs.REG_RD_DATA;

        if (start_det) begin
            state_d = DEV_ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (scl_rise) begin
            unique case (state_q)
                DEV_ADDR: begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        if (addr_hit) begin
                            state_d = DEV_ACK;
                            cnt_d   = 4'd8;
                            busy_d  = 1'b1;
                            rw_d    = byte_in[0];
                            if (byte_in[0]) begin
                                rd_stb_d  = 1'b1;
                                rd_addr_d = ptr_q;
                            end
                        end else begin
                            state_d = IDLE;
                            cnt_d   = 4'd0;
                        end
                    end
                end
                PTR: begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        ptr_d   = byte_in;
                        state_d = PTR_ACK;
                    end
                end
                WR_DATA: begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = byte_in;
                        ptr_d     = ptr_q + 8'd1;
                        state_d   = WR_ACK;
                    end
                end
                DEV_ACK, PTR_ACK, WR_ACK: cnt_d = cnt_q + 4'd1;
                RD_DATA: begin
                    cnt_d   = cnt_q + 4'd1;
                    shift_d = {shift_q[6:0], 1'b0};
                end
                RD_ACK: begin
                    cnt_d = 4'd0;
                    if (!sda_lvl_d) begin
                        ptr_d     = ptr_q + 8'd1;
                        rd_stb_d  = 1'b1;
                        rd_addr_d = ptr_q + 8'd1;
                        state_d   = RD_DATA;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            // cnt 8: ACK clock starts, drive low; cnt 9: ACK clock done.
            unique case (state_q)
                DEV_ACK: begin
                    if (cnt_q == 4'd9) begin
                        cnt_d = 4'd0;
                        if (rw_q) begin
                            state_d = RD_DATA;
                            oe_d    = ~shift_q[7];
                        end else begin
                            state_d = PTR;
                            oe_d    = 1'b0;
                        end
                    end else begin
                        oe_d = 1'b1;
                    end
                end
                PTR_ACK, WR_ACK: begin
                    if (cnt_q == 4'd9) begin
                        state_d = WR_DATA;
                        cnt_d   = 4'd0;
                        oe_d    = 1'b0;
                    end else begin
                        oe_d = 1'b1;
                    end
                end
                RD_DATA: begin
                    if (cnt_q == 4'd8) begin
                        state_d = RD_ACK;
                        cnt_d   = 4'd0;
                        oe_d    = 1'b0;
                    end else begin
                        oe_d = ~shift_q[7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_lvl_q  <= 1'b1;
            sda_lvl_q  <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'd0;
            ptr_q      <= PTR_RESET;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            ld_q       <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 8'd0;
            rd_stb_q   <= 1'b0;
            rd_addr_q  <= PTR_RESET;
        end else begin
            scl_sync_q <= {scl_sync_q[0], SCL};
            sda_sync_q <= {sda_sync_q[0], SDA};
            scl_lvl_q  <= scl_lvl_d;
            sda_lvl_q  <= sda_lvl_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            ld_q       <= ld_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_stb_q   <= rd_stb_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    assign SDA              = oe_q ? 1'b0 : 1'bz;
    assign BUSY             = busy_q;
    assign regs.REG_WR_EN   = wr_en_q;
    assign regs.REG_WR_ADDR = wr_addr_q;
    assign regs.REG_WR_DATA = wr_data_q;
    assign regs.REG_RD_STB  = rd_stb_q;
    assign regs.REG_RD_ADDR = rd_addr_q;
endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C controller, register-file responder,
// reference memory/pointer model, directed and randomized transactions.
module tb_i2c_target_regs;
    localparam int Q = 8;

    logic clk = 1'b0;
    logic rst;
    logic scl;
    logic tb_sda_low;
    logic busy;
    wire  sda;

    int checks = 0;
    int failures = 0;

    logic [7:0]  regf    [256];
    logic [7:0]  exp_mem [256];
    logic [7:0]  ptr_m;
    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];
    int          low_cnt = 0;
    int          busy_cnt = 0;

    always #5 clk = ~clk;

    assign sda = tb_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_target_regs_if regs_if ();

    i2c_target_regs dut (
        .CLK  (clk),
        .RST  (rst),
        .SCL  (scl),
        .SDA  (sda),
        .BUSY (busy),
        .regs (regs_if)
    );

    always @(posedge clk)
        if (regs_if.REG_RD_STB)
            regs_if.REG_RD_DATA <= regf[regs_if.REG_RD_ADDR];

    always @(negedge clk) begin
        if (regs_if.REG_WR_EN)
            wr_q.push_back({regs_if.REG_WR_ADDR, regs_if.REG_WR_DATA});
        if (regs_if.REG_RD_STB)
            rd_q.push_back(regs_if.REG_RD_ADDR);
        if (!tb_sda_low && sda === 1'b0)
            low_cnt <= low_cnt + 1;
        if (busy)
            busy_cnt <= busy_cnt + 1;
    end

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        tb_sda_low = 1'b1; wq(Q);
        scl = 1'b0; wq(Q);
    endtask

    task automatic bus_rstart();
        tb_sda_low = 1'b0; wq(Q);
        scl = 1'b1; wq(Q);
        tb_sda_low = 1'b1; wq(Q);
        scl = 1'b0; wq(Q);
    endtask

    task automatic bus_stop();
        tb_sda_low = 1'b1; wq(Q);
        scl = 1'b1; wq(Q);
        tb_sda_low = 1'b0; wq(Q);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        tb_sda_low = ~b; wq(Q);
        scl = 1'b1; wq(Q);
        s = sda; wq(Q);
        scl = 1'b0; wq(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], d);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] v);
        logic d;
        for (int i = 7; i >= 0; i--) clk_bit(1'b1, v[i]);
        clk_bit(nack, d);
    endtask

    task automatic do_reset();
        rst = 1'b1; scl = 1'b1; tb_sda_low = 1'b0;
        wq(3);
        rst = 1'b0;
        wq(3);
        ptr_m = 8'h00;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (regs_if.REG_WR_EN !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", regs_if.REG_WR_EN); end
        checks++; if (regs_if.REG_RD_STB !== 1'b0) begin failures++; $display("FAIL reset_rd_stb got=%b exp=0", regs_if.REG_RD_STB); end
        checks++; if (regs_if.REG_WR_ADDR !== 8'h00) begin failures++; $display("FAIL reset_wr_addr got=%h exp=00", regs_if.REG_WR_ADDR); end
        checks++; if (regs_if.REG_WR_DATA !== 8'h00) begin failures++; $display("FAIL reset_wr_data got=%h exp=00", regs_if.REG_WR_DATA); end
        checks++; if (regs_if.REG_RD_ADDR !== 8'h00) begin failures++; $display("FAIL reset_rd_addr got=%h exp=00", regs_if.REG_RD_ADDR); end
        checks++; if (sda !== 1'b1) begin failures++; $display("FAIL reset_sda got=%b exp=1", sda); end
    endtask

    task automatic test_write_basic();
        logic [3:0] a;
        logic [15:0] e[$];
        wr_q.delete();
        bus_start();
        write_byte(8'h84, a[0]);
        write_byte(8'h10, a[1]);
        write_byte(8'hA5, a[2]);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy_mid got=%b exp=1", busy); end
        write_byte(8'h5A, a[3]);
        bus_stop();
        wq(4);
        e = '{16'h10A5, 16'h115A};
        ptr_m = 8'h12;
        checks++; if (a !== 4'b0000) begin failures++; $display("FAIL wr_acks got=%b exp=0000", a); end
        checks++; if (wr_q.size() != e.size()) begin failures++; $display("FAIL wr_count got=%0d exp=%0d", wr_q.size(), e.size()); end
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (i >= wr_q.size() || wr_q[i] !== e[i]) begin
                failures++; $display("FAIL wr_event%0d got=%h exp=%h", i, (i < wr_q.size()) ? wr_q[i] : 16'hxxxx, e[i]);
            end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_stop got=%b exp=0", busy); end
    endtask

    task automatic test_read_basic();
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        regf[8'h20] = 8'h11; exp_mem[8'h20] = 8'h11;
        regf[8'h21] = 8'h22; exp_mem[8'h21] = 8'h22;
        rd_q.delete();
        bus_start();
        write_byte(8'h84, a0);
        write_byte(8'h20, a1);
        bus_rstart();
        write_byte(8'h85, a2);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        wq(4);
        ptr_m = 8'h21;
        checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL rd_acks got=%b exp=000", {a0, a1, a2}); end
        checks++; if (d0 !== 8'h11) begin failures++; $display("FAIL rd_byte0 got=%h exp=11", d0); end
        checks++; if (d1 !== 8'h22) begin failures++; $display("FAIL rd_byte1 got=%h exp=22", d1); end
        checks++; if (rd_q.size() != 2) begin failures++; $display("FAIL rd_stb_count got=%0d exp=2", rd_q.size()); end
        checks++; if (rd_q.size() > 0 && rd_q[0] !== 8'h20) begin failures++; $display("FAIL rd_addr0 got=%h exp=20", rd_q[0]); end
        checks++; if (rd_q.size() > 1 && rd_q[1] !== 8'h21) begin failures++; $display("FAIL rd_addr1 got=%h exp=21", rd_q[1]); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd_busy_nack got=%b exp=0", busy); end
        checks++; if (sda !== 1'b1) begin failures++; $display("FAIL rd_sda_nack got=%b exp=1", sda); end
        bus_stop();
    endtask

    task automatic test_wrong_addr();
        logic a0, a1;
        int l0, b0;
        wr_q.delete();
        l0 = low_cnt; b0 = busy_cnt;
        bus_start();
        write_byte(8'h86, a0);
        write_byte(8'hFF, a1);
        bus_stop();
        wq(4);
        checks++; if ({a0, a1} !== 2'b11) begin failures++; $display("FAIL na_acks got=%b exp=11", {a0, a1}); end
        checks++; if (low_cnt != l0) begin failures++; $display("FAIL na_sda_low got=%0d exp=0", low_cnt - l0); end
        checks++; if (busy_cnt != b0) begin failures++; $display("FAIL na_busy got=%0d exp=0", busy_cnt - b0); end
        checks++; if (wr_q.size() != 0) begin failures++; $display("FAIL na_writes got=%0d exp=0", wr_q.size()); end
    endtask

    task automatic test_wrap();
        logic [3:0] a;
        logic [15:0] e[$];
        wr_q.delete();
        bus_start();
        write_byte(8'h84, a[0]);
        write_byte(8'hFF, a[1]);
        write_byte(8'h01, a[2]);
        write_byte(8'h02, a[3]);
        bus_stop();
        wq(4);
        e = '{16'hFF01, 16'h0002};
        ptr_m = 8'h01;
        checks++; if (a !== 4'b0000) begin failures++; $display("FAIL wrap_acks got=%b exp=0000", a); end
        checks++; if (wr_q.size() != e.size()) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", wr_q.size(), e.size()); end
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (i >= wr_q.size() || wr_q[i] !== e[i]) begin
                failures++; $display("FAIL wrap_event%0d got=%h exp=%h", i, (i < wr_q.size()) ? wr_q[i] : 16'hxxxx, e[i]);
            end
        end
    endtask

    task automatic test_partial_stop();
        logic a0, a1, d;
        wr_q.delete();
        bus_start();
        write_byte(8'h84, a0);
        write_byte(8'h30, a1);
        for (int i = 0; i < 4; i++) clk_bit(i[0], d);
        bus_stop();
        wq(4);
        ptr_m = 8'h30;
        checks++; if (wr_q.size() != 0) begin failures++; $display("FAIL partial_writes got=%0d exp=0", wr_q.size()); end
        checks++; if (sda !== 1'b1) begin failures++; $display("FAIL partial_sda got=%b exp=1", sda); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL partial_busy got=%b exp=0", busy); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [7:0] p, d, v, q;
            logic a, ack_or;
            int n, m;
            logic [15:0] e[$];
            logic [7:0] ea[$];
            p = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 4);
            wr_q.delete();
            ack_or = 1'b0;
            bus_start();
            write_byte(8'h84, a); ack_or |= a;
            write_byte(p, a); ack_or |= a;
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                write_byte(d, a); ack_or |= a;
                exp_mem[8'(p + i)] = d;
                e.push_back({8'(p + i), d});
            end
            bus_stop();
            wq(4);
            ptr_m = 8'(p + n);
            checks++; if (ack_or !== 1'b0) begin failures++; $display("FAIL rnd%0d_wr_acks got=%b exp=0", it, ack_or); end
            checks++;
            if (wr_q != e) begin
                failures++; $display("FAIL rnd%0d_writes got_n=%0d exp_n=%0d first_exp=%h", it, wr_q.size(), e.size(), e[0]);
            end
            foreach (wr_q[k]) regf[wr_q[k][15:8]] = wr_q[k][7:0];

            // Even: read on from the persisted pointer; odd: re-point to p.
            m = $urandom_range(1, 3);
            rd_q.delete();
            ack_or = 1'b0;
            bus_start();
            if (it % 2 == 1) begin
                write_byte(8'h84, a); ack_or |= a;
                write_byte(p, a); ack_or |= a;
                ptr_m = p;
                bus_rstart();
            end
            write_byte(8'h85, a); ack_or |= a;
            q = ptr_m;
            for (int j = 0; j < m; j++) begin
                read_byte(j == m - 1, v);
                ea.push_back(8'(q + j));
                checks++;
                if (v !== exp_mem[8'(q + j)]) begin
                    failures++; $display("FAIL rnd%0d_rd%0d got=%h exp=%h", it, j, v, exp_mem[8'(q + j)]);
                end
            end
            bus_stop();
            wq(4);
            ptr_m = 8'(q + m - 1);
            checks++; if (ack_or !== 1'b0) begin failures++; $display("FAIL rnd%0d_rd_acks got=%b exp=0", it, ack_or); end
            checks++;
            if (rd_q != ea) begin
                failures++; $display("FAIL rnd%0d_rd_addrs got_n=%0d exp_n=%0d first_exp=%h", it, rd_q.size(), ea.size(), ea[0]);
            end
        end
    endtask

    task automatic test_rst_midread();
        logic a;
        regf[8'h55] = 8'h00; exp_mem[8'h55] = 8'h00;
        bus_start();
        write_byte(8'h84, a);
        write_byte(8'h55, a);
        bus_rstart();
        write_byte(8'h85, a);
        tb_sda_low = 1'b0; wq(Q);
        scl = 1'b1; wq(Q);
        checks++; if (sda !== 1'b0) begin failures++; $display("FAIL rst_pre_drive got=%b exp=0", sda); end
        #3 rst = 1'b1;
        #1;
        checks++; if (sda !== 1'b1) begin failures++; $display("FAIL rst_sda_async got=%b exp=1", sda); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (regs_if.REG_RD_ADDR !== 8'h00) begin failures++; $display("FAIL rst_rd_addr got=%h exp=00", regs_if.REG_RD_ADDR); end
        checks++; if (regs_if.REG_WR_ADDR !== 8'h00) begin failures++; $display("FAIL rst_wr_addr got=%h exp=00", regs_if.REG_WR_ADDR); end
        checks++; if (regs_if.REG_WR_DATA !== 8'h00) begin failures++; $display("FAIL rst_wr_data got=%h exp=00", regs_if.REG_WR_DATA); end
        checks++; if ({regs_if.REG_WR_EN, regs_if.REG_RD_STB} !== 2'b00) begin failures++; $display("FAIL rst_strobes got=%b exp=00", {regs_if.REG_WR_EN, regs_if.REG_RD_STB}); end
        wq(2);
        rst = 1'b0;
        wq(4);
        ptr_m = 8'h00;
    endtask

    task automatic test_glitch();
        logic a0, a1, a2;
        logic [7:0] b;
        logic [15:0] e;
        b = 8'h3C;
        wr_q.delete();
        bus_start();
        write_byte(8'h84, a0);
        write_byte(8'h40, a1);
        for (int i = 0; i < 8; i++) begin
            tb_sda_low = ~b[7 - i]; wq(Q);
            scl = 1'b1; wq(3);
            if (i == 2) begin
                scl = 1'b0; wq(2);
                scl = 1'b1;
            end
            wq(2 * Q - 3);
            scl = 1'b0; wq(Q);
        end
        clk_bit(1'b1, a2);
        bus_stop();
        wq(4);
        ptr_m = 8'h41;
`ifdef I2C_GLITCH_FILTER_EN
        e = 16'h403C;
`else
        e = 16'h403E;
`endif
        checks++; if ({a0, a1} !== 2'b00) begin failures++; $display("FAIL glitch_acks got=%b exp=00", {a0, a1}); end
        checks++; if (wr_q.size() != 1) begin failures++; $display("FAIL glitch_count got=%0d exp=1", wr_q.size()); end
        checks++; if (wr_q.size() > 0 && wr_q[0] !== e) begin failures++; $display("FAIL glitch_event got=%h exp=%h", wr_q[0], e); end
    endtask

    initial begin
        logic [7:0] v;
        for (int k = 0; k < 256; k++) begin
            v = 8'($urandom);
            regf[k] = v;
            exp_mem[k] = v;
        end
        test_reset();
        test_write_basic();
        test_read_basic();
        test_wrong_addr();
        test_wrap();
        test_partial_stop();
        test_random();
        test_rst_midread();
        test_glitch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
